// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the icache
// and the dcache. One transaction in flight; the winning request is latched
// and replayed to memory, and the response is steered back to its owner.
module cache_line_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic [CNT_WIDTH-1:0]  i_gnt_cnt,
    output logic [CNT_WIDTH-1:0]  d_gnt_cnt
);

    localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t                state;
    state_t                state_n;
    logic                  last_d;
    logic                  grant_i;
    logic                  grant_d;
    logic                  i_req;
    logic                  d_req;
    logic                  op_write;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Strobes come straight from state so a reset drops them immediately.
    assign mem_read  = (state != IDLE) & ~op_write;
    assign mem_write = (state != IDLE) &  op_write;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

    // Arbitration in IDLE, response steering and completion while busy.
    always_comb begin
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_d)) begin
                    grant_i = 1'b1;
                    state_n = BUSY_I;
                end else if (d_req) begin
                    grant_d = 1'b1;
                    state_n = BUSY_D;
                end
            end
            BUSY_I: begin
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    state_n = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register and the round-robin history bit, updated on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b1;
        end else begin
            state <= state_n;
            if (i_resp) begin
                last_d <= 1'b0;
            end else if (d_resp) begin
                last_d <= 1'b1;
            end
        end
    end

    // Latch the winning request so port activity while busy has no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            op_write <= 1'b0;
            wdata_q  <= '0;
        end else if (grant_i || grant_d) begin
            addr_q   <= (grant_d ? d_addr : i_addr) & LINE_MASK;
            op_write <= grant_d & d_write;
            wdata_q  <= d_wdata;
        end
    end

    // Saturating per-port grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_gnt_cnt <= '0;
            d_gnt_cnt <= '0;
        end else begin
            if (grant_i && (i_gnt_cnt != '1)) begin
                i_gnt_cnt <= i_gnt_cnt + CNT_WIDTH'(1);
            end
            if (grant_d && (d_gnt_cnt != '1)) begin
                d_gnt_cnt <= d_gnt_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Scoreboard bench for cache_line_arbiter: a transaction-level model predicts
// each memory transaction at grant time; a negedge monitor checks them.
module tb_cache_line_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;
    localparam int unsigned CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic          i_read, d_read, d_write, i_resp, d_resp;
    logic          mem_read, mem_write, mem_resp;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic [CW-1:0] i_gnt_cnt, d_gnt_cnt;

    cache_line_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .i_gnt_cnt(i_gnt_cnt), .d_gnt_cnt(d_gnt_cnt)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        bit            is_d;
        logic [AW-1:0] addr;
        bit            wr;
        logic [LW-1:0] wdata;
        int            launch;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference-model and stimulus state.
    bit model_busy = 0;
    bit owner_d    = 0;
    bit last_d_m   = 1;
    int lat        = -1;
    int lat_min    = 3;
    int lat_max    = 3;
    bit resp_en    = 1;
    bit spur_en    = 0;
    int issue_pct  = 0;
    int i_left     = 0;
    int d_left     = 0;

    function automatic void check(string name, logic [LW-1:0] act, logic [LW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < int'(LW / 32); i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic issue_i(input logic [AW-1:0] a);
        i_read = 1'b1;
        i_addr = a;
    endtask

    task automatic set_d(input logic [AW-1:0] a, input bit rd, input bit wr, input logic [LW-1:0] wd);
        d_read  = rd;
        d_write = wr;
        d_addr  = a;
        d_wdata = wd;
    endtask

    task automatic issue_d_rand();
        int op;
        op = $urandom_range(2);
        set_d($urandom, op != 1, op != 0, rand_line());
    endtask

    task automatic wait_slot();
        @(posedge clk);
        #1;
    endtask

    // Everything the bench does in one cycle, in a fixed order.
    task automatic slot_body();
        int   done_port;
        bit   ir, dr, win_d;
        logic strobe;
        txn_t t;
        done_port = 0;
        if (mem_resp && model_busy) begin
            model_busy = 0;
            last_d_m   = owner_d;
            done_port  = owner_d ? 2 : 1;
        end
        if (done_port == 1) i_read = 1'b0;
        if (done_port == 2) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        if (!i_read && i_left > 0 && $urandom_range(99) < issue_pct) begin
            issue_i($urandom);
            i_left--;
        end
        if (!(d_read || d_write) && d_left > 0 && $urandom_range(99) < issue_pct) begin
            issue_d_rand();
            d_left--;
        end
        if (model_busy && $urandom_range(3) == 0) begin
            if (owner_d) begin
                d_addr  = $urandom;
                d_wdata = rand_line();
            end else begin
                i_addr = $urandom;
            end
        end
        if (!model_busy) begin
            ir = i_read;
            dr = d_read || d_write;
            if (ir || dr) begin
                win_d    = (ir && dr) ? !last_d_m : dr;
                t.is_d   = win_d;
                t.addr   = (win_d ? d_addr : i_addr) & ~32'h1F;
                t.wr     = win_d && d_write;
                t.wdata  = d_wdata;
                t.launch = cyc + 1;
                exp_q.push_back(t);
                model_busy = 1;
                owner_d    = win_d;
            end
        end
        strobe = mem_read | mem_write;
        if (mem_resp) begin
            mem_resp = 1'b0;
        end else if (resp_en) begin
            if (lat < 0 && strobe) lat = $urandom_range(lat_max, lat_min);
            if (lat == 0) begin
                mem_resp  = 1'b1;
                mem_rdata = rand_line();
                lat       = -1;
            end else if (lat > 0) begin
                lat--;
            end else if (spur_en && !strobe && !model_busy && $urandom_range(15) == 0) begin
                mem_resp  = 1'b1;
                mem_rdata = rand_line();
            end
        end
    endtask

    task automatic tick();
        wait_slot();
        slot_body();
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((model_busy || i_read || d_read || d_write || i_left > 0 || d_left > 0 ||
                exp_q.size() > 0 || mem_resp) && n < max) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= max) begin
            n_fail++;
            $display("FAIL drain_timeout: still busy after %0d cycles, %0d txns pending", n, exp_q.size());
        end
        tick();
        tick();
    endtask

    // Monitor: pops the scoreboard on each new memory transaction.
    bit   active = 0;
    bit   mon_d  = 0;
    bit   prev_strobe = 0;
    int   icnt = 0;
    int   dcnt = 0;
    initial forever begin
        txn_t e;
        logic strobe;
        @(negedge clk);
        if (rst) begin
            active      = 0;
            prev_strobe = 0;
            icnt        = 0;
            dcnt        = 0;
            check("reset_strobes", {mem_read, mem_write}, '0);
            check("reset_mem_addr", mem_addr, '0);
            check("reset_mem_wdata", mem_wdata, '0);
            check("reset_resp", {i_resp, d_resp}, '0);
            check("reset_counters", {i_gnt_cnt, d_gnt_cnt}, '0);
        end else begin
            strobe = mem_read | mem_write;
            check("strobe_onehot", mem_read & mem_write, '0);
            check("strobe_after_resp", strobe && prev_strobe && !active, '0);
            if (strobe && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_txn: addr %h with no grant predicted", mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("launch_cycle", cyc, e.launch);
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_write", mem_write, e.wr);
                    check("mem_read", mem_read, !e.wr);
                    if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
                    if (e.is_d) dcnt = (dcnt == CNT_MAX) ? CNT_MAX : dcnt + 1;
                    else        icnt = (icnt == CNT_MAX) ? CNT_MAX : icnt + 1;
                    check("i_gnt_cnt", i_gnt_cnt, icnt);
                    check("d_gnt_cnt", d_gnt_cnt, dcnt);
                    active = 1;
                    mon_d  = e.is_d;
                end
            end
            if (mem_resp && active) begin
                check("i_resp", i_resp, !mon_d);
                check("d_resp", d_resp, mon_d);
                check("owner_rdata", mon_d ? d_rdata : i_rdata, mem_rdata);
                active = 0;
            end else begin
                check("resp_quiet", {i_resp, d_resp}, '0);
            end
            prev_strobe = strobe;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Simultaneous requests right after reset, then continuous contention.
        wait_slot();
        issue_i($urandom);
        issue_d_rand();
        i_left = 3; d_left = 3; issue_pct = 100;
        slot_body();
        drain(300);
        issue_pct = 0;

        // Single icache read, memory latency 3.
        wait_slot();
        issue_i(32'h0000_1234);
        slot_body();
        drain(50);

        // Dirty write-back.
        wait_slot();
        set_d(32'h8000_0040, 1'b0, 1'b1, {8{32'hDEADBEEF}});
        slot_body();
        drain(50);

        // Port activity while BUSY_D.
        wait_slot();
        set_d(32'h0000_0100, 1'b1, 1'b0, rand_line());
        slot_body();
        tick();
        tick();
        wait_slot();
        d_addr = 32'hFFFF_FFE0;
        issue_i(32'h0000_5678);
        slot_body();
        drain(50);

        // Random traffic with variable latency and stray responses.
        lat_min = 0; lat_max = 3; spur_en = 1;
        i_left = 60; d_left = 60; issue_pct = 40;
        drain(5000);
        issue_pct = 0; spur_en = 0;
        check("d_cnt_saturated", d_gnt_cnt, 4'hF);
        check("i_cnt_saturated", i_gnt_cnt, 4'hF);

        // Reset two cycles into BUSY_I.
        resp_en = 0;
        wait_slot();
        issue_i(32'h0000_2468);
        slot_body();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_async_mem_read", mem_read, '0);
        check("rst_async_mem_write", mem_write, '0);
        check("rst_async_counters", {i_gnt_cnt, d_gnt_cnt}, '0);
        exp_q.delete();
        model_busy = 0; last_d_m = 1; lat = -1;
        i_read = 1'b0;
        tick();
        tick();
        wait_slot();
        rst = 1'b0;
        slot_body();
        mem_resp  = 1'b1;
        mem_rdata = rand_line();
        #1;
        check("spurious_resp", {i_resp, d_resp}, '0);
        tick();
        resp_en = 1;

        // Post-reset contention: icache must win the first tie again.
        wait_slot();
        issue_i($urandom);
        issue_d_rand();
        i_left = 5; d_left = 5; issue_pct = 100;
        slot_body();
        drain(400);
        issue_pct = 0;

        check("final_i_cnt", i_gnt_cnt, icnt);
        check("final_d_cnt", d_gnt_cnt, dcnt);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
